// File: rtl/inst_fetch_queue_pkg.sv
// Shared MIPS instruction-format constants for fetch, decode and hazard logic.
// Latency: none (constants only).
// Backpressure: not applicable.
package inst_fetch_queue_pkg;

  // Bubble inserted when the queue is empty: sll $0,$0,0.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Field bit positions within a 32-bit MIPS instruction.
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int IMM_HI = 15;
  localparam int TGT_HI = 25;

endpackage

// File: rtl/inst_field_split.sv
// Splits a MIPS instruction into its R/I/J fields.
// Latency: purely combinational.
// Backpressure: none; the fields follow the input directly.
module inst_field_split
  import inst_fetch_queue_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm16_o,
  output logic [25:0] target_o
);

  assign opcode_o = inst_i[OPC_HI:OPC_LO];
  assign rs_o     = inst_i[RS_HI:RS_LO];
  assign rt_o     = inst_i[RT_HI:RT_LO];
  assign rd_o     = inst_i[RD_HI:RD_LO];
  assign shamt_o  = inst_i[SH_HI:SH_LO];
  assign funct_o  = inst_i[FN_HI:0];
  assign imm16_o  = inst_i[IMM_HI:0];
  assign target_o = inst_i[TGT_HI:0];

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular instruction buffer between fetch and decode; head presented pre-split into MIPS fields.
// Latency: 1 cycle from accepted push to out_valid (no bypass).
// Backpressure: in_ready drops only when full, from registered occupancy; flush empties the queue next cycle.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_inst,
  input  logic [PC_W-1:0]            in_pc4,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_inst,
  output logic [PC_W-1:0]            out_pc4,
  output logic [5:0]                 out_opcode,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_shamt,
  output logic [5:0]                 out_funct,
  output logic [15:0]                out_imm16,
  output logic [25:0]                out_target,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] inst_mem_q [DEPTH];
  logic [PC_W-1:0]   pc4_mem_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  // Handshake status comes only from registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt_q;

  // Next-state pointers and occupancy; flush overrides any push/pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state with synchronous reset taking priority over flush, push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; stale contents are harmless because empty output is forced to a bubble.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      inst_mem_q[wr_ptr_q] <= in_inst;
      pc4_mem_q[wr_ptr_q]  <= in_pc4;
    end
  end

  assign out_inst = out_valid ? inst_mem_q[rd_ptr_q] : DATA_W'(NOP_INST);
  assign out_pc4  = out_valid ? pc4_mem_q[rd_ptr_q]  : '0;

  inst_field_split u_split (
    .inst_i   (out_inst),
    .opcode_o (out_opcode),
    .rs_o     (out_rs),
    .rt_o     (out_rt),
    .rd_o     (out_rd),
    .shamt_o  (out_shamt),
    .funct_o  (out_funct),
    .imm16_o  (out_imm16),
    .target_o (out_target)
  );

endmodule
